direction_input: RTL

// - Upstream stage of the move controller: turns the four raw active-low push-buttons into

---
 rtl/game2048_pkg.sv | 27 ++
 rtl/key_debounce.sv | 57 +++++
 rtl/direction_input.sv | 85 ++++++++
 3 files changed

// File: rtl/game2048_pkg.sv
`default_nettype none
// ============================================================================
// Module   : game2048_pkg
// Purpose  : Direction encoding shared by direction_input and the move
//            controller, plus a one-hot helper used by press detection.
// Contents : dir_t type, DIR_* one-hot constants, is_one_hot()
// Revision : 1.0 - initial release
// ============================================================================
package game2048_pkg;

    // Bit order matches the key_n bus: [3]=up [2]=down [1]=left [0]=right.
    typedef logic [3:0] dir_t;

    localparam dir_t DIR_UP    = 4'b1000;
    localparam dir_t DIR_DOWN  = 4'b0100;
    localparam dir_t DIR_LEFT  = 4'b0010;
    localparam dir_t DIR_RIGHT = 4'b0001;
    localparam dir_t DIR_NONE  = 4'b0000;

    // True when exactly one bit is set: clearing the lowest set bit must
    // leave nothing behind.
    function automatic logic is_one_hot(input dir_t v);
        return (v != DIR_NONE) && ((v & (v - 4'd1)) == DIR_NONE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Purpose  : One push-button conditioner: 2-flop synchroniser on the inverted
//            (active-high) key level, then a persistence counter that only
//            lets a level through after it has held for DEBOUNCE_CYCLES
//            consecutive cycles.
// Ports    : clock  in  1  system clock
//            reset  in  1  synchronous, active-high reset
//            raw_n  in  1  raw button, active low, asynchronous
//            stable out  1  debounced pressed level (active high)
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_n,
    output logic stable
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_s1 <= ~raw_n;
            r_s2 <= r_s1;
            // The counter measures how long the synchronised level has
            // disagreed with the accepted level; any agreement restarts it,
            // so short glitches never reach the accepted level.
            if (r_s2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_stable <= r_s2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign stable = r_stable;

endmodule
`default_nettype wire

// File: rtl/direction_input.sv
`default_nettype none
// ============================================================================
// Module   : direction_input
// Purpose  : Turns four raw active-low buttons into clean one-hot move
//            requests held in a single-entry valid/ready buffer for the move
//            controller.
// Ports    : clock      in   1  system clock, sole clock domain
//            reset      in   1  synchronous, active-high reset
//            key_n      in   4  raw buttons, active low [3]=up [2]=down
//                               [1]=left [0]=right
//            dir_ready  in   1  controller can accept a move this cycle
//            dir_valid  out  1  direction holds an untaken move
//            direction  out  4  one-hot move, 0 whenever dir_valid=0
//            dropped    out  1  pulse: accepted press lost to a full buffer
//            keys_down  out  4  debounced pressed state (active high)
// Revision : 1.0 - initial release
// ============================================================================
module direction_input
    import game2048_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] key_n,
    input  logic       dir_ready,
    output logic       dir_valid,
    output logic [3:0] direction,
    output logic       dropped,
    output logic [3:0] keys_down
);

    dir_t w_stable;
    dir_t r_stable_d;
    logic w_press;
    logic w_transfer;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_key_debounce (
                .clock  (clock),
                .reset  (reset),
                .raw_n  (key_n[gi]),
                .stable (w_stable[gi])
            );
        end
    endgenerate

    // A press only counts when the previous cycle had every key released and
    // exactly one key is now down. This rejects chords, presses made while
    // another key is held, releases, and auto-repeat on a held key.
    assign w_press    = (r_stable_d == DIR_NONE) && is_one_hot(w_stable);
    assign w_transfer = dir_valid && dir_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stable_d <= DIR_NONE;
            dir_valid  <= 1'b0;
            direction  <= DIR_NONE;
            dropped    <= 1'b0;
        end else begin
            r_stable_d <= w_stable;

            // A load is allowed on the same edge the old move is taken, so
            // the buffer can hand over and refill without a bubble.
            if (w_press && (!dir_valid || w_transfer)) begin
                dir_valid <= 1'b1;
                direction <= w_stable;
            end else if (w_transfer) begin
                dir_valid <= 1'b0;
                direction <= DIR_NONE;
            end

            dropped <= w_press && dir_valid && !dir_ready;
        end
    end

    assign keys_down = w_stable;

endmodule
`default_nettype wire
